// File: rtl/seven_seg_mux.sv
// seven_seg_mux
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits that
//   share one segment bus. Each digit owns a slot of REFRESH_CYCLES clocks.
//   The first BLANK_CYCLES clocks of every slot are dead time, with all
//   outputs off, to suppress ghosting.
//
//   Digit data is double buffered. A load writes the shadow register. The
//   shadow is copied to the active register only when the scan wraps back to
//   digit 0, so a frame never shows a mix of old and new data.
//
//   Handshake: there is no valid/ready pair. load is a one-cycle strobe that
//   is sampled on every rising edge, and frame_done is a one-cycle pulse the
//   consumer may count. digit_en is sampled live.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   en           1 = scan; 0 = all digits dark, slot counter cleared, idx held
//   load         capture digits/dp_in into the shadow register
//   digits       hex nibble per digit, digit d = digits[4d+3:4d]
//   dp_in        decimal point per digit, 1 = lit
//   digit_en     1 = digit shown, 0 = digit blanked
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   anode        one-hot digit select; active low when ANODE_ACT_LOW = 1
//   digit_idx    digit that owns the presented slot
//   frame_done   one-cycle pulse when digit 0 slot 0 is presented after a wrap
module seven_seg_mux #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 200,
  parameter int ANODE_ACT_LOW  = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              en,
  input  logic                                              load,
  input  logic [4*NUM_DIGITS-1:0]                           digits,
  input  logic [NUM_DIGITS-1:0]                             dp_in,
  input  logic [NUM_DIGITS-1:0]                             digit_en,
  output logic [6:0]                                        seg,
  output logic                                              dp,
  output logic [NUM_DIGITS-1:0]                             anode,
  output logic [$clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2)-1:0] digit_idx,
  output logic                                              frame_done
);

  localparam int CNT_W = $clog2((REFRESH_CYCLES > 1) ? REFRESH_CYCLES : 2);
  localparam int IDX_W = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACT_LOW != 0) ? '1 : '0;

  // Per-slot phase. It is a pure function of the slot counter, so the
  // counter is the state register.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  logic [CNT_W-1:0]                 slot_cnt, slot_cnt_next;
  logic [IDX_W-1:0]                 idx, idx_next;
  logic [NUM_DIGITS-1:0][3:0]       shadow, active;
  logic [NUM_DIGITS-1:0]            shadow_dp, active_dp;
  logic                             wrap_pending;
  logic                             slot_wrap, frame_wrap;
  phase_t                           phase;
  logic [6:0]                       seg_next;
  logic                             dp_next;
  logic [NUM_DIGITS-1:0]            anode_on, anode_next;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_wrap  = (slot_cnt == CNT_LAST);
  // The wrap from the last digit back to digit 0 marks a frame boundary.
  assign frame_wrap = en && slot_wrap && (idx == IDX_LAST);

  always_comb begin
    slot_cnt_next = slot_cnt;
    idx_next      = idx;
    phase         = PH_BLANK;
    seg_next      = 7'h7F;
    dp_next       = 1'b1;
    anode_on      = '0;

    if (!en) begin
      slot_cnt_next = '0;
    end else if (slot_wrap) begin
      slot_cnt_next = '0;
      idx_next      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt_next = slot_cnt + 1'b1;
    end

    // A digit blanked through digit_en looks exactly like dead time.
    if (en && (slot_cnt >= CNT_BLANK) && digit_en[idx]) begin
      phase = PH_SHOW;
    end

    if (phase == PH_SHOW) begin
      seg_next      = decode(active[idx]);
      dp_next       = ~active_dp[idx];
      anode_on[idx] = 1'b1;
    end

    anode_next = (ANODE_ACT_LOW != 0) ? ~anode_on : anode_on;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt     <= '0;
      idx          <= '0;
      shadow       <= '0;
      shadow_dp    <= '0;
      active       <= '0;
      active_dp    <= '0;
      wrap_pending <= 1'b0;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      anode        <= ANODE_OFF;
      digit_idx    <= '0;
      frame_done   <= 1'b0;
    end else begin
      slot_cnt     <= slot_cnt_next;
      idx          <= idx_next;
      seg          <= seg_next;
      dp           <= dp_next;
      anode        <= anode_next;
      // Outputs lag the counter by one cycle. The wrap is remembered for one
      // edge so that the pulse lines up with digit 0 slot 0 being presented.
      wrap_pending <= frame_wrap;
      frame_done   <= en & wrap_pending;
      if (en) begin
        digit_idx <= idx;
      end
      // This copy reads the old shadow, so a load on the wrap edge itself
      // reaches the display one frame later.
      if (frame_wrap) begin
        active    <= shadow;
        active_dp <= shadow_dp;
      end
      if (load) begin
        shadow    <= digits;
        shadow_dp <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux
//   Scoreboard bench for seven_seg_mux with NUM_DIGITS=2, R=8, B=2 and
//   active-low anodes. A driver task applies one cycle of inputs. It then
//   advances a behavioural model of the display and pushes the expected
//   outputs for that cycle into exp_q. A separate monitor pops exp_q on every
//   falling edge and compares the queued values with the DUT outputs.
module tb_seven_seg_mux;
  localparam int N = 2;
  localparam int R = 8;
  localparam int B = 2;
  localparam int W = 12;   // {seg[6:0], dp, anode[1:0], digit_idx, frame_done}

  logic           clk = 1'b0;
  logic           reset, en, load;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in, digit_en;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   anode;
  logic [0:0]     digit_idx;
  logic           frame_done;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  seven_seg_mux #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .ANODE_ACT_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .digits(digits),
    .dp_in(dp_in), .digit_en(digit_en), .seg(seg), .dp(dp), .anode(anode),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The display is modelled in terms of "which digit owns the scan, how many
  // enabled cycles into its slot it is, and what the current frame shows".
  logic [6:0] seg_tab [16];
  int         m_age;          // enabled cycles already spent in this slot
  int         m_digit;        // digit owning the slot
  int         m_shown [N];    // hex values of the frame being displayed
  int         m_shown_dp [N];
  int         m_pend [N];     // last loaded values, waiting for the next frame
  int         m_pend_dp [N];
  bit         m_new_frame;    // a frame boundary has just been crossed
  int         m_last_idx;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  function automatic logic [W-1:0] pack(input logic [6:0] s, input logic d,
                                        input logic [1:0] a, input int di,
                                        input logic fd);
    return {s, d, a, di[0], fd};
  endfunction

  task automatic model_reset();
    m_age = 0; m_digit = 0; m_new_frame = 0; m_last_idx = 0;
    for (int i = 0; i < N; i++) begin
      m_shown[i] = 0; m_shown_dp[i] = 0; m_pend[i] = 0; m_pend_dp[i] = 0;
    end
  endtask

  // Expected outputs presented after an edge with the given inputs.
  task automatic model_edge(input logic r, input logic e, input logic l,
                            input logic [4*N-1:0] d, input logic [N-1:0] dpi,
                            input logic [N-1:0] de);
    logic [W-1:0] x;
    if (r) begin
      model_reset();
      x = pack(7'h7F, 1'b1, 2'b11, 0, 1'b0);
    end else if (!e) begin
      x = pack(7'h7F, 1'b1, 2'b11, m_last_idx, 1'b0);
      m_age = 0;
      m_new_frame = 0;
    end else begin
      if (m_age >= B && de[m_digit])
        x = pack(seg_tab[m_shown[m_digit]], m_shown_dp[m_digit] == 0,
                 2'b11 ^ (2'b01 << m_digit), m_digit, m_new_frame);
      else
        x = pack(7'h7F, 1'b1, 2'b11, m_digit, m_new_frame);
      m_last_idx  = m_digit;
      m_new_frame = 0;
      m_age++;
      if (m_age == R) begin
        m_age   = 0;
        m_digit = (m_digit + 1) % N;
        if (m_digit == 0) begin
          // A new frame starts from whatever was loaded before this edge.
          m_new_frame = 1;
          m_shown     = m_pend;
          m_shown_dp  = m_pend_dp;
        end
      end
    end
    if (!r && l) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i]    = int'(d[4*i +: 4]);
        m_pend_dp[i] = int'(dpi[i]);
      end
    end
    exp_q.push_back(x);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [4*N-1:0] d, input logic [N-1:0] dpi,
                      input logic [N-1:0] de);
    reset = r; en = e; load = l; digits = d; dp_in = dpi; digit_en = de;
    @(posedge clk);
    cycle++;
    model_edge(r, e, l, d, dpi, de);
    #1;
  endtask

  task automatic idle(input int n, input logic e, input logic [N-1:0] de);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 8'h00, 2'b00, de);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {seg, dp, anode, digit_idx, frame_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cycle %0d: seg/dp/anode/idx/fd got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 cycle, got[11:5], got[4], got[3:2], got[1], got[0],
                 want[11:5], want[4], want[3:2], want[1], want[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] de_cur;
    model_reset();
    reset = 1'b1; en = 1'b1; load = 1'b0; digits = '0; dp_in = '0; digit_en = '1;

    // Reset held for 5 cycles with en high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 2'b11);
    cycle = 0;

    // Frame 1 shows zeros; load A5 with dp on digit 0 at cycle 4.
    idle(3, 1'b1, 2'b11);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 2'b01, 2'b11);
    idle(28, 1'b1, 2'b11);

    // Digit 0 blanked through digit_en for a full frame.
    idle(16, 1'b1, 2'b10);

    // Drop en during a SHOW window, hold it low, then resume.
    idle(12, 1'b1, 2'b11);
    idle(7, 1'b0, 2'b11);
    step(1'b0, 1'b0, 1'b1, 8'h3C, 2'b10, 2'b11);   // load while scan is held
    idle(20, 1'b1, 2'b11);

    // Load on the exact frame-wrap edge: the old shadow must be displayed.
    while (!(dut.idx == 1'b1 && dut.slot_cnt == 3'd7)) idle(1, 1'b1, 2'b11);
    step(1'b0, 1'b1, 1'b1, 8'h71, 2'b11, 2'b11);
    idle(34, 1'b1, 2'b11);

    // Reset during SHOW after loading FF; afterwards digits show 0.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 2'b11, 2'b11);
    idle(20, 1'b1, 2'b11);
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 2'b11);
    idle(34, 1'b1, 2'b11);

    // Randomised traffic.
    de_cur = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) de_cur = N'($urandom_range(0, 3));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 9) == 0, 8'($urandom), N'($urandom_range(0, 3)),
           de_cur);
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
